// File: rtl/harness_mul_pipe.sv
// harness_mul_pipe: pipelined parametrised multiplier with running accumulate and valid/ready flow control.
// Define HARNESS_MUL_PIPE_SAT_EN to clamp overflowing results to the dout range instead of wrapping.
module harness_mul_pipe #(
    parameter int din0_WIDTH  = 8,
    parameter int din1_WIDTH  = 5,
    parameter int dout_WIDTH  = 13,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 1,
    parameter int NUM_STAGE   = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  in_acc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  out_ovf
);
    localparam bit S0 = DIN0_SIGNED != 0;
    localparam bit S1 = DIN1_SIGNED != 0;
    localparam bit RS = S0 | S1;
    localparam int PW = din0_WIDTH + din1_WIDTH + ((S0 != S1) ? 1 : 0);
    localparam int RW = ((PW > dout_WIDTH) ? PW : dout_WIDTH) + 1;
    localparam logic [dout_WIDTH-1:0] SMIN = dout_WIDTH'(1) << (dout_WIDTH - 1);

    logic                  adv;
    logic [PW-1:0]         a, b, p, fp;
    logic                  fa, fv;
    logic [RW-1:0]         pe, de, r;
    logic                  ovf;
    logic [dout_WIDTH-1:0] nxt;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Extending both operands to the full product width makes a plain PW-bit multiply exact
    assign a = {{(PW-din0_WIDTH){S0 & din0[din0_WIDTH-1]}}, din0};
    assign b = {{(PW-din1_WIDTH){S1 & din1[din1_WIDTH-1]}}, din1};
    assign p = a * b;

    generate
        if (NUM_STAGE == 1) begin : g_direct
            assign fp = p;
            assign fa = in_acc;
            assign fv = in_valid;
        end else begin : g_pipe
            logic [PW-1:0]        sp [NUM_STAGE-1];
            logic [NUM_STAGE-2:0] sa, sv;
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    sa <= '0;
                    sv <= '0;
                    for (int i = 0; i < NUM_STAGE - 1; i++) sp[i] <= '0;
                end else if (adv) begin
                    sp[0] <= p;
                    sa[0] <= in_acc;
                    sv[0] <= in_valid;
                    for (int i = 1; i < NUM_STAGE - 1; i++) begin
                        sp[i] <= sp[i-1];
                        sa[i] <= sa[i-1];
                        sv[i] <= sv[i-1];
                    end
                end
            end
            assign fp = sp[NUM_STAGE-2];
            assign fa = sa[NUM_STAGE-2];
            assign fv = sv[NUM_STAGE-2];
        end
    endgenerate

    assign pe  = {{(RW-PW){RS & fp[PW-1]}}, fp};
    assign de  = {{(RW-dout_WIDTH){RS & dout[dout_WIDTH-1]}}, dout};
    assign r   = fa ? de + pe : pe;
    // Signed range holds when all bits from the dout sign bit upward agree
    assign ovf = RS ? (r[RW-1:dout_WIDTH-1] != '0 && r[RW-1:dout_WIDTH-1] != '1)
                    : (r[RW-1:dout_WIDTH] != '0);
`ifdef HARNESS_MUL_PIPE_SAT_EN
    assign nxt = !ovf ? r[dout_WIDTH-1:0] : !RS ? '1 : r[RW-1] ? SMIN : ~SMIN;
`else
    assign nxt = r[dout_WIDTH-1:0];
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            out_ovf   <= 1'b0;
        end else if (adv) begin
            out_valid <= fv;
            if (fv) begin
                dout    <= nxt;
                out_ovf <= ovf;
            end
        end
    end
endmodule

// File: tb/tb_harness_mul_pipe.sv
// tb_harness_mul_pipe: randomized and directed checks of two harness_mul_pipe configurations against an arithmetic model.
module tb_harness_mul_pipe;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        in_valid, in_acc, out_ready0, out_ready1;
    logic [7:0]  din0;
    logic [4:0]  din1;
    logic        in_ready0, out_valid0, out_ovf0;
    logic        in_ready1, out_valid1, out_ovf1;
    logic [12:0] dout0, dout1;

    int          checks = 0;
    int          errors = 0;
    int          n0 = 0;
    logic [13:0] q0[$], q1[$];
    logic [13:0] e0, e1;
    logic [12:0] prev0 = '0, prev1 = '0;
    bit          h0 = 0, h1 = 0;
    logic [12:0] hd0, hd1;
    logic        ho0, ho1;

`ifdef HARNESS_MUL_PIPE_SAT_EN
    localparam logic [12:0] ACC_S = 13'd4096;
    localparam logic [12:0] ACC_U = 13'd8191;
`else
    localparam logic [12:0] ACC_S = 13'd32;
    localparam logic [12:0] ACC_U = 13'd7618;
`endif

    always #5 ap_clk = ~ap_clk;

    harness_mul_pipe u0 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .din0(din0), .din1(din1), .in_acc(in_acc), .out_valid(out_valid0),
        .out_ready(out_ready0), .dout(dout0), .out_ovf(out_ovf0)
    );

    harness_mul_pipe #(.DIN1_SIGNED(0), .NUM_STAGE(1)) u1 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .din0(din0), .din1(din1), .in_acc(in_acc), .out_valid(out_valid1),
        .out_ready(out_ready1), .dout(dout1), .out_ovf(out_ovf1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected {ovf, dout} for 8-bit unsigned din0 times 5-bit din1 (signed when s) into 13 bits
    function automatic logic [13:0] model(input logic [7:0] a, input logic [4:0] b,
                                          input logic acc, input logic [12:0] prev, input bit s);
        longint pb, pv, r, lo, hi;
        logic [12:0] d;
        logic o;
        if (s) begin
            pb = longint'($signed(b));
            pv = longint'($signed(prev));
            lo = -4096;
            hi = 4095;
        end else begin
            pb = longint'({1'b0, b});
            pv = longint'({1'b0, prev});
            lo = 0;
            hi = 8191;
        end
        r = (acc ? pv : 64'sd0) + longint'({1'b0, a}) * pb;
        o = (r < lo) || (r > hi);
        d = r[12:0];
`ifdef HARNESS_MUL_PIPE_SAT_EN
        if (r < lo) d = lo[12:0];
        else if (r > hi) d = hi[12:0];
`endif
        return {o, d};
    endfunction

    // Handshakes sampled mid-cycle take effect on the following rising edge
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            h0 = 0;
            h1 = 0;
        end else begin
            if (h0) begin
                check("u0_hold_valid", 32'(out_valid0), 32'd1);
                check("u0_hold_dout", 32'(dout0), 32'(hd0));
                check("u0_hold_ovf", 32'(out_ovf0), 32'(ho0));
            end
            if (h1) begin
                check("u1_hold_valid", 32'(out_valid1), 32'd1);
                check("u1_hold_dout", 32'(dout1), 32'(hd1));
                check("u1_hold_ovf", 32'(out_ovf1), 32'(ho1));
            end
            h0 = out_valid0 && !out_ready0;
            hd0 = dout0;
            ho0 = out_ovf0;
            h1 = out_valid1 && !out_ready1;
            hd1 = dout1;
            ho1 = out_ovf1;
            if (in_valid && in_ready0) begin
                e0 = model(din0, din1, in_acc, prev0, 1'b1);
                q0.push_back(e0);
                prev0 = e0[12:0];
            end
            if (in_valid && in_ready1) begin
                e1 = model(din0, din1, in_acc, prev1, 1'b0);
                q1.push_back(e1);
                prev1 = e1[12:0];
            end
            if (out_valid0 && out_ready0) begin
                if (q0.size() == 0) check("u0_unexpected", 32'(out_valid0), 32'd0);
                else begin
                    e0 = q0.pop_front();
                    check("u0_dout", 32'(dout0), 32'(e0[12:0]));
                    check("u0_ovf", 32'(out_ovf0), 32'(e0[13]));
                    n0++;
                end
            end
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) check("u1_unexpected", 32'(out_valid1), 32'd0);
                else begin
                    e1 = q1.pop_front();
                    check("u1_dout", 32'(dout1), 32'(e1[12:0]));
                    check("u1_ovf", 32'(out_ovf1), 32'(e1[13]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        int k, base;
        logic took;
        ap_rst_n = 1'b0;
        in_valid = 1'b0;
        in_acc = 1'b0;
        din0 = '0;
        din1 = '0;
        out_ready0 = 1'b1;
        out_ready1 = 1'b1;
        #12 ap_rst_n = 1'b1;
        tick();
        check("rst_valid0", 32'(out_valid0), 32'd0);
        check("rst_dout0", 32'(dout0), 32'd0);
        check("rst_ovf0", 32'(out_ovf0), 32'd0);
        check("rst_ready0", 32'(in_ready0), 32'd1);
        check("rst_valid1", 32'(out_valid1), 32'd0);
        check("rst_ready1", 32'(in_ready1), 32'd1);

        // 255 x -16, then the same beat accumulated
        in_valid = 1'b1;
        din0 = 8'd255;
        din1 = 5'h10;
        tick();
        check("lat_u0_early", 32'(out_valid0), 32'd0);
        check("lat_u1_valid", 32'(out_valid1), 32'd1);
        check("u1_mul", 32'(dout1), 32'd4080);
        in_acc = 1'b1;
        tick();
        check("lat_u0_valid", 32'(out_valid0), 32'd1);
        check("u0_mul", 32'(dout0), 32'd4112);
        check("u0_mul_ovf", 32'(out_ovf0), 32'd0);
        check("u1_acc", 32'(dout1), 32'd8160);
        in_valid = 1'b0;
        tick();
        check("u0_acc_ovf_dout", 32'(dout0), 32'(ACC_S));
        check("u0_acc_ovf", 32'(out_ovf0), 32'd1);
        check("u1_bubble", 32'(out_valid1), 32'd0);

        // unsigned config: 255 x 31, then accumulated past 8191
        in_valid = 1'b1;
        in_acc = 1'b0;
        din1 = 5'd31;
        tick();
        check("u1_umul", 32'(dout1), 32'd7905);
        check("u1_umul_ovf", 32'(out_ovf1), 32'd0);
        in_acc = 1'b1;
        tick();
        check("u1_uacc", 32'(dout1), 32'(ACC_U));
        check("u1_uacc_ovf", 32'(out_ovf1), 32'd1);
        in_valid = 1'b0;
        tick();
        tick();

        // six beats on u0 with out_ready low for three cycles mid-stream
        base = n0;
        k = 0;
        din0 = 8'($urandom);
        din1 = 5'($urandom);
        in_acc = 1'($urandom);
        for (int c = 0; c < 30 && k < 6; c++) begin
            out_ready0 = !(c >= 3 && c < 6);
            in_valid = 1'b1;
            #1;
            if (c >= 3 && c < 6) check("bp_in_ready", 32'(in_ready0), 32'd0);
            took = in_ready0;
            tick();
            if (took) begin
                k++;
                din0 = 8'($urandom);
                din1 = 5'($urandom);
                in_acc = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        out_ready0 = 1'b1;
        repeat (4) tick();
        check("bp_count", 32'(n0 - base), 32'd6);

        // asynchronous reset with two beats in flight
        in_valid = 1'b1;
        in_acc = 1'b1;
        din0 = 8'($urandom);
        din1 = 5'($urandom);
        tick();
        din0 = 8'($urandom);
        tick();
        #1 ap_rst_n = 1'b0;
        q0.delete();
        q1.delete();
        prev0 = '0;
        prev1 = '0;
        #1;
        check("arst_valid0", 32'(out_valid0), 32'd0);
        check("arst_dout0", 32'(dout0), 32'd0);
        check("arst_valid1", 32'(out_valid1), 32'd0);
        check("arst_dout1", 32'(dout1), 32'd0);
        in_valid = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        repeat (3) tick();
        check("arst_quiet0", 32'(out_valid0), 32'd0);
        check("arst_quiet1", 32'(out_valid1), 32'd0);
        in_valid = 1'b1;
        in_acc = 1'b1;
        din0 = 8'd3;
        din1 = 5'd2;
        tick();
        in_valid = 1'b0;
        check("arst_acc1", 32'(dout1), 32'd6);
        tick();
        check("arst_acc0", 32'(dout0), 32'd6);
        check("arst_acc0_valid", 32'(out_valid0), 32'd1);

        // random traffic; u1 sees out_ready toggling every cycle
        for (int c = 0; c < 400; c++) begin
            in_valid = $urandom_range(0, 3) != 0;
            din0 = 8'($urandom);
            din1 = 5'($urandom);
            in_acc = 1'($urandom);
            out_ready0 = $urandom_range(0, 2) != 0;
            out_ready1 = c[0];
            tick();
        end
        in_valid = 1'b0;
        out_ready0 = 1'b1;
        out_ready1 = 1'b1;
        repeat (6) tick();
        check("drain_q0", 32'(q0.size()), 32'd0);
        check("drain_q1", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
